// File: rtl/rom_access_arbiter.sv
// Shares the single-port instruction ROM between the fetch (F) and data-load (D)
// requesters, with optional wait states, registered read data and range flagging.
module rom_access_arbiter #(
    parameter int ROM_WORDS   = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int RR_MODE     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        busy,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic        rr_last_r;
    logic        port_r;
    logic        f_gnt_s;
    logic        d_gnt_s;
    logic [28:0] sel_idx_s;
    logic        in_range_s;
    logic [31:0] cap_data_s;
    logic        unused_s;

    function automatic logic word_in_range(input logic [28:0] idx);
        return ({3'b000, idx} < 32'($unsigned(ROM_WORDS)));
    endfunction

    // Grant decision: only while idle, never more than one port per cycle.
    always_comb begin
        f_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (state_r == IDLE) begin
            if (f_req && d_req) begin
                if ((RR_MODE != 0) && (rr_last_r == PORT_D)) begin
                    f_gnt_s = 1'b1;
                end else begin
                    d_gnt_s = 1'b1;
                end
            end else begin
                f_gnt_s = f_req;
                d_gnt_s = d_req;
            end
        end else begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    assign f_gnt      = f_gnt_s;
    assign d_gnt      = d_gnt_s;
    assign sel_idx_s  = d_gnt_s ? d_addr[30:2] : f_addr[30:2];
    // The latched ROM address doubles as the word index for the range test.
    assign in_range_s = word_in_range(rom_addr[30:2]);
    assign cap_data_s = in_range_s ? rom_data : 32'h0000_0000;
    // Supervisor bit and byte offset carry no meaning for the ROM.
    assign unused_s   = ^{f_addr[31], f_addr[1:0], d_addr[31], d_addr[1:0]};

    // Access sequencer: latch on grant, count wait states, capture into the owner port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            rr_last_r <= PORT_F;
            port_r    <= PORT_F;
            f_rdata   <= 32'h0000_0000;
            d_rdata   <= 32'h0000_0000;
            f_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rom_addr  <= 32'h0000_0000;
        end else begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            err      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (f_gnt_s || d_gnt_s) begin
                        port_r    <= d_gnt_s;
                        rr_last_r <= d_gnt_s;
                        rom_addr  <= {1'b0, sel_idx_s, 2'b00};
                        cnt_r     <= 2'(WAIT_CYCLES);
                        state_r   <= ACCESS;
                        busy      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else begin
                        if (port_r == PORT_D) begin
                            d_rdata  <= cap_data_s;
                            d_rvalid <= 1'b1;
                        end else begin
                            f_rdata  <= cap_data_s;
                            f_rvalid <= 1'b1;
                        end
                        err     <= ~in_range_s;
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: three configurations (RR, fixed priority, 3 wait states)
// driven by directed then random requesters, checked against a cycle-count reference model.
`timescale 1ns/1ps
module tb_rom_access_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   mode = 0;   // 0 directed lists, 1 random traffic, 2 quiet
    bit   done = 1'b0;
    logic [31:0] dir_f[$];
    logic [31:0] dir_d[$];

    typedef struct {
        bit          port;
        int          cyc;
        logic [31:0] data;
        bit          err;
    } exp_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM contents: the first words carry the values the instruction stream is known to hold.
    function automatic logic [31:0] rom_word(input int idx);
        case (idx)
            0:       return 32'h0800_0003;
            3:       return 32'h3C04_4000;
            4:       return 32'h2002_0008;
            5:       return 32'hAC82_0018;
            default: return (32'(idx) * 32'h0101_0203) ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int sel;
        a   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 8) a[30:2] = 29'($urandom_range(0, 31));
        else if (sel == 8) a[30:2] = 29'($urandom_range(32, 40));
        return a;
    endfunction

    // Requester behaviour: hold until granted, then take the next address.
    task automatic next_req(input bit is_d, input bit seen, input bit held,
                            input logic [31:0] cur, inout int ptr,
                            output bit req, output logic [31:0] addr);
        bit dropped;
        req     = held;
        addr    = cur;
        dropped = 1'b0;
        if (reset == 1'b0) begin
            req = 1'b0;
        end else begin
            if (held && seen) req = 1'b0;
            else if (held && mode == 1 && $urandom_range(0, 7) == 0) begin
                req     = 1'b0;
                dropped = 1'b1;
            end
            if (!req && !dropped) begin
                if (mode == 0 && is_d && ptr < dir_d.size()) begin
                    req = 1'b1; addr = dir_d[ptr]; ptr++;
                end else if (mode == 0 && !is_d && ptr < dir_f.size()) begin
                    req = 1'b1; addr = dir_f[ptr]; ptr++;
                end else if (mode == 1 && $urandom_range(0, 2) != 0) begin
                    req = 1'b1; addr = rand_addr();
                end
            end
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W  = (g == 2) ? 3 : 0;
        localparam int RR = (g == 1) ? 0 : 1;

        logic        f_req, d_req, f_gnt, d_gnt, f_rvalid, d_rvalid, err, busy;
        logic [31:0] f_addr, d_addr, f_rdata, d_rdata, rom_addr, rom_data;
        exp_t        q[$];
        int          idle_from = 0;
        int          last_grant = 0;
        bit          rr_last = 1'b0;
        logic [31:0] exp_f = 32'h0, exp_d = 32'h0, exp_ra = 32'h0;
        bit          f_seen = 1'b0, d_seen = 1'b0, end_done = 1'b0;
        int          f_ptr = 0, d_ptr = 0;

        assign rom_data = (rom_addr[30:2] < 29'd32) ? rom_word(int'(rom_addr[6:2])) : 32'hDEAD_BEEF;

        rom_access_arbiter #(.ROM_WORDS(32), .WAIT_CYCLES(W), .RR_MODE(RR)) u_dut (
            .clk(clk), .reset(reset),
            .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
            .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
            .err(err), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data)
        );

        initial begin
            bit nf, nd;
            logic [31:0] af, ad;
            f_req = 1'b0; d_req = 1'b0; f_addr = 32'h0; d_addr = 32'h0;
            forever begin
                @(posedge clk);
                #2;
                next_req(1'b0, f_seen, f_req, f_addr, f_ptr, nf, af);
                next_req(1'b1, d_seen, d_req, d_addr, d_ptr, nd, ad);
                f_req = nf; f_addr = af;
                d_req = nd; d_addr = ad;
            end
        end

        // Reference model and scoreboard monitor, evaluated mid-cycle.
        initial begin
            int c;
            bit eg_f, eg_d, ebusy;
            exp_t e;
            logic [31:0] a;
            logic [28:0] idx;
            forever begin
                @(negedge clk);
                c = cyc;
                f_seen = f_gnt;
                d_seen = d_gnt;
                eg_f = 1'b0;
                eg_d = 1'b0;
                if (c >= 2) begin
                    ebusy = (c > last_grant) && (c < idle_from);
                    if (!ebusy) begin
                        if (f_req && d_req) begin
                            eg_d = (RR == 0) || (rr_last == 1'b0);
                            eg_f = !eg_d;
                        end else begin
                            eg_f = f_req;
                            eg_d = d_req;
                        end
                    end
                    check($sformatf("cfg%0d f_gnt", g), f_gnt, eg_f);
                    check($sformatf("cfg%0d d_gnt", g), d_gnt, eg_d);
                    check($sformatf("cfg%0d busy", g), busy, ebusy);
                    check($sformatf("cfg%0d rom_addr", g), rom_addr, exp_ra);
                    if (f_rvalid || d_rvalid) begin
                        if (q.size() == 0) begin
                            check($sformatf("cfg%0d spurious rvalid", g), {30'b0, d_rvalid, f_rvalid}, 32'd0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("cfg%0d rvalid cycle", g), 32'(c), 32'(e.cyc));
                            check($sformatf("cfg%0d rvalid port", g), {30'b0, d_rvalid, f_rvalid},
                                  e.port ? 32'd2 : 32'd1);
                            check($sformatf("cfg%0d err", g), err, e.err);
                            if (e.port) exp_d = e.data; else exp_f = e.data;
                        end
                    end else begin
                        check($sformatf("cfg%0d err without rvalid", g), err, 1'b0);
                        if (q.size() > 0 && q[0].cyc <= c) begin
                            e = q.pop_front();
                            check($sformatf("cfg%0d missing rvalid", g), {30'b0, d_rvalid, f_rvalid},
                                  e.port ? 32'd2 : 32'd1);
                            if (e.port) exp_d = e.data; else exp_f = e.data;
                        end
                    end
                    check($sformatf("cfg%0d f_rdata", g), f_rdata, exp_f);
                    check($sformatf("cfg%0d d_rdata", g), d_rdata, exp_d);
                    if (done && !end_done) begin
                        check($sformatf("cfg%0d outstanding", g), 32'(q.size()), 32'd0);
                        end_done = 1'b1;
                    end
                end
                if (reset == 1'b0) begin
                    q.delete();
                    idle_from = c + 1;
                    last_grant = c;
                    rr_last = 1'b0;
                    exp_f = 32'h0; exp_d = 32'h0; exp_ra = 32'h0;
                end else if (eg_f || eg_d) begin
                    a = eg_d ? d_addr : f_addr;
                    idx = a[30:2];
                    idle_from = c + 2 + W;
                    last_grant = c;
                    rr_last = eg_d;
                    exp_ra = {1'b0, idx, 2'b00};
                    e.port = eg_d;
                    e.cyc  = c + 2 + W;
                    e.data = (idx < 29'd32) ? rom_word(int'(idx)) : 32'h0;
                    e.err  = (idx >= 29'd32);
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        // Fetch alone from word 0.
        dir_f.push_back(32'h0000_0000);
        repeat (12) @(posedge clk);
        #1;
        // Both requesters held together on three accesses each.
        for (int i = 0; i < 3; i++) begin
            dir_f.push_back(32'h0000_0010);
            dir_d.push_back(32'h0000_0014);
        end
        repeat (40) @(posedge clk);
        #1;
        // Data load alone with the supervisor bit set.
        dir_d.push_back(32'h8000_000C);
        repeat (12) @(posedge clk);
        #1;
        // Out-of-range word then a normal one.
        dir_d.push_back(32'h0000_0100);
        dir_d.push_back(32'h0000_0014);
        repeat (20) @(posedge clk);
        #1;
        // Grant at cycle t, reset low during cycle t+2 aborts the 3-wait access.
        dir_f.push_back(32'h0000_0004);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        dir_f.push_back(32'h0000_0008);
        repeat (15) @(posedge clk);
        #1 mode = 1;
        repeat (3000) @(posedge clk);
        #1 mode = 2;
        repeat (30) @(posedge clk);
        #1 done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
Arbitrates the single-port instruction ROM between two requesters: the instruction-fetch port (F) and the data-load port (D), used by lw from the ROM region. It sequences each ROM access through an optional wait-state counter and returns registered read data with a one-cycle valid pulse to the granted requester. It also flags out-of-range word addresses. It sits between the CPU core ports and the combinational ROM.

Parameters:
ROM_WORDS, 32, number of implemented ROM words; word index = addr[30:2].
WAIT_CYCLES, 0, extra ROM access cycles (0..3) before data capture.
RR_MODE, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, D over F.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
f_req  in  1  fetch request; held with f_addr stable until f_gnt
f_addr  in  32  fetch byte address
f_gnt  out  1  fetch granted this cycle (combinational)
f_rvalid  out  1  one-cycle pulse: f_rdata valid
f_rdata  out  32  fetch read data (registered)
d_req  in  1  data-load request; held with d_addr stable until d_gnt
d_addr  in  32  data byte address
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  one-cycle pulse: d_rdata valid
d_rdata  out  32  data read data (registered)
err  out  1  pulses with the rvalid of an out-of-range access
busy  out  1  high while state is ACCESS
rom_addr  out  32  address to ROM: {1'b0, latched addr[30:2], 2'b00}
rom_data  in  32  combinational ROM output

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, wait counter 0, rr_last=F.
- Reset clears f_rdata, d_rdata, f_rvalid, d_rvalid, err and rom_addr to 0.
- An in-flight access is aborted and produces no rvalid.
- FSM states are IDLE and ACCESS.
- IDLE, grants:
  - Grants are issued only in IDLE; at most one gnt per cycle; gnt=0 in ACCESS.
  - Only one requester: grant it.
  - Both requesting, RR_MODE=1: grant the port that is not rr_last.
  - Both requesting, RR_MODE=0: grant D.
- On grant at cycle t:
  - Latch the granted address and the port id.
  - rr_last <= granted port.
  - State -> ACCESS; counter <= WAIT_CYCLES.
- ACCESS:
  - rom_addr is driven from the latched address.
  - If counter != 0, decrement the counter.
  - If counter == 0, capture into the granted port's rdata and set its rvalid for the next cycle; state -> IDLE.
  - Data captured: rom_data if the word index < ROM_WORDS, else 32'h0 with err=1.
- Latency:
  - gnt at cycle t, rvalid at cycle t+2+WAIT_CYCLES.
  - The IDLE cycle carrying rvalid may issue the next grant, giving back-to-back period WAIT_CYCLES+2.
- The rdata of a port holds its value until that port's next capture; the other port's rdata is unaffected.
- rvalid and err are single-cycle pulses; err is 0 whenever no rvalid is high.
- Addressing:
  - addr[31] (supervisor bit) and addr[1:0] are ignored; no misalignment error.
  - Word index comparison is unsigned on 29 bits.
- No request in IDLE: all outputs hold, rvalid=0.
- A requester dropping req before gnt is legal and never granted.
- Dropping req after gnt does not cancel the access.

Test Plan:
- Reset, F only, f_addr=0x00000000, WAIT_CYCLES=0 -> f_gnt at t, f_rvalid at t+2, f_rdata=0x08000003, err=0, d_rvalid stays 0.
- D only, d_addr=0x8000000C -> d_rdata=0x3C044000 (bit 31 ignored), rom_addr=0x0000000C during ACCESS.
- F and D held together, RR_MODE=1, f_addr=0x10, d_addr=0x14, three grants:
  - grants alternate D, F, D;
  - d_rdata=0xAC820018, f_rdata=0x20020008;
  - rvalid pulses 2 cycles apart.
- Same simultaneous stimulus with RR_MODE=0 -> D is granted every time while held; F is granted only after d_req drops.
- d_addr=0x00000100 (word 64 >= 32) -> d_rvalid with d_rdata=0x00000000 and err=1; next in-range access gives err=0.
- WAIT_CYCLES=3 with a grant at t, then reset low at t+2 -> no rvalid; all outputs are 0 and busy=0 after the reset edge. Next grant completes at grant+5.
